// File: rtl/obi_burst_loader_if.sv
// Bundle of host push, base-load, OBI request/response and status signals
// for obi_burst_loader. The master modport is the loader's view; the slave
// modport is the view of whatever drives the host side and answers the bus.
interface obi_burst_loader_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    // Host side
    logic                     base_addr_valid_i;
    logic [31:0]              base_addr_i;
    logic                     wr_valid_i;
    logic [31:0]              wr_data_i;
    logic                     wr_ready_o;
    // OBI request channel
    logic                     req_o;
    logic                     we_o;
    logic [3:0]               be_o;
    logic [31:0]              addr_o;
    logic [31:0]              wdata_o;
    // OBI grant / response
    logic                     gnt_i;
    logic                     rvalid_i;
    logic [31:0]              rdata_i;
    // Status
    logic                     busy_o;
    logic [$clog2(DEPTH):0]   level_o;
    logic [CNT_W-1:0]         count_o;
    logic                     addr_err_o;
    logic                     mismatch_o;

    modport master (
        input  base_addr_valid_i, base_addr_i, wr_valid_i, wr_data_i,
               gnt_i, rvalid_i, rdata_i,
        output wr_ready_o, req_o, we_o, be_o, addr_o, wdata_o,
               busy_o, level_o, count_o, addr_err_o, mismatch_o
    );

    modport slave (
        output base_addr_valid_i, base_addr_i, wr_valid_i, wr_data_i,
               gnt_i, rvalid_i, rdata_i,
        input  wr_ready_o, req_o, we_o, be_o, addr_o, wdata_o,
               busy_o, level_o, count_o, addr_err_o, mismatch_o
    );
endinterface

// File: rtl/obi_burst_loader.sv
// obi_burst_loader: buffers host words in a small FIFO and writes them over
// OBI to consecutive word addresses starting at a loadable base pointer.
// Optional macro OBI_LOADER_READBACK_EN adds a read-back of every written word
// and a sticky mismatch flag; without it mismatch_o is tied low.
module obi_burst_loader #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    obi_burst_loader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef OBI_LOADER_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ_W, S_WAIT_W, S_REQ_R, S_WAIT_R} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ_W, S_WAIT_W} state_t;
`endif

    state_t            state_q, state_d;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              req_q, req_d, we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              addr_err_q, addr_err_d;
    logic              push, pop, done, busy;
`ifdef OBI_LOADER_READBACK_EN
    logic [31:0]       data_q, data_d;
    logic              mismatch_q, mismatch_d;
`endif

    assign push = bus.wr_valid_i && (level_q < LW'(DEPTH));
    assign busy = (state_q != S_IDLE) || (level_q != '0);

    // FIFO storage: written on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.wr_data_i;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
    end

    // Sequencer: base loads, request generation and completion bookkeeping.
    // Entering REQ_W spends one cycle loading the request registers from the
    // FIFO head, so the request outputs are pure flops and hold until grant.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        addr_err_d = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
`ifdef OBI_LOADER_READBACK_EN
        data_d     = data_q;
        mismatch_d = mismatch_q;
`endif
        if (bus.base_addr_valid_i) begin
            if (busy) begin
                addr_err_d = 1'b1;
            end else begin
                ptr_d   = {bus.base_addr_i[31:2], 2'b00};
                count_d = '0;
`ifdef OBI_LOADER_READBACK_EN
                mismatch_d = 1'b0;
`endif
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) state_d = S_REQ_W;
            end
            S_REQ_W: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    be_d    = 4'hF;
                    wdata_d = mem[rd_ptr_q];
                end else if (bus.gnt_i) begin
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                    wdata_d = '0;
`ifdef OBI_LOADER_READBACK_EN
                    data_d  = wdata_q;
`endif
                    state_d = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                if (bus.rvalid_i) begin
`ifdef OBI_LOADER_READBACK_EN
                    state_d = S_REQ_R;
                    req_d   = 1'b1;
                    be_d    = 4'hF;
`else
                    done    = 1'b1;
`endif
                end
            end
`ifdef OBI_LOADER_READBACK_EN
            S_REQ_R: begin
                if (bus.gnt_i) begin
                    req_d   = 1'b0;
                    be_d    = 4'h0;
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (bus.rvalid_i) begin
                    if (bus.rdata_i != data_q) mismatch_d = 1'b1;
                    done = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            ptr_d   = ptr_q + 32'd4;
            state_d = S_IDLE;
            if (count_q != '1) count_d = count_q + CNT_W'(1);
        end
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
`ifdef OBI_LOADER_READBACK_EN
            data_q     <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
`ifdef OBI_LOADER_READBACK_EN
            data_q     <= data_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign bus.wr_ready_o = (level_q < LW'(DEPTH));
    assign bus.req_o      = req_q;
    assign bus.we_o       = we_q;
    assign bus.be_o       = be_q;
    assign bus.addr_o     = ptr_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.busy_o     = busy;
    assign bus.level_o    = level_q;
    assign bus.count_o    = count_q;
    assign bus.addr_err_o = addr_err_q;
`ifdef OBI_LOADER_READBACK_EN
    assign bus.mismatch_o = mismatch_q;
`else
    assign bus.mismatch_o = 1'b0;
`endif
endmodule

// File: doc/obi_burst_loader.md
OBI_BURST_LOADER -- requirements
Module: obi_burst_loader

Interface
REQ-001 Parameter DEPTH, default 8: FIFO depth in 32-bit words; power of two, 2..64.
REQ-002 Parameter CNT_W, default 16: width of the written-word counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 base_addr_valid_i  in  1  requests a load of base_addr_i into the write pointer.
REQ-006 base_addr_i  in  32  new target address; bits [1:0] ignored, treated as 0.
REQ-007 wr_valid_i / wr_data_i / wr_ready_o  in 1 / in 32 / out 1  host word push; a word transfers when valid and ready are both high.
REQ-008 req_o, we_o, be_o[3:0], addr_o[31:0], wdata_o[31:0]  out  OBI master request channel.
REQ-009 gnt_i, rvalid_i, rdata_i[31:0]  in  OBI grant and response.
REQ-010 busy_o  out  1  FSM not in IDLE, or FIFO not empty.
REQ-011 level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 count_o  out  CNT_W  words completed since the last base load; saturates at all-ones.
REQ-013 addr_err_o  out  1  one-cycle pulse when a base load is rejected.
REQ-014 mismatch_o  out  1  sticky read-back mismatch flag (see Configuration).

Function
REQ-015 FIFO: wr_ready_o = (level_o < DEPTH); a push is refused when full; no overflow or underflow is possible.
REQ-016 FSM states: IDLE, REQ_W, WAIT_W, plus REQ_R and WAIT_R under the macro.
REQ-017 IDLE -> REQ_W when the FIFO is non-empty; a word pushed on edge k gives req_o=1 from edge k+2.
REQ-018 In REQ_W: req_o=1, we_o=1, be_o=4'hF, addr_o=write pointer, wdata_o=FIFO head. All request outputs hold stable until gnt_i.
REQ-019 REQ_W with gnt_i: pop the FIFO head into a data register, drop req_o on the next edge, enter WAIT_W.
REQ-020 WAIT_W with rvalid_i: write pointer += 4 (wraps modulo 2^32), count_o += 1 (saturating), go to IDLE (or REQ_R when the macro is enabled).
REQ-021 Only one OBI transaction is outstanding at any time; gnt_i outside the REQ states and rvalid_i outside the WAIT states are ignored.
REQ-022 A base load is accepted only when busy_o=0: the pointer takes base_addr_i, count_o clears, mismatch_o clears.
REQ-023 A base load requested while busy_o=1 is ignored, and addr_err_o pulses for 1 cycle.
REQ-024 Base load and push in the same cycle while idle: the address takes priority, so the pushed word goes to the new base.
REQ-025 A push and a pop in the same cycle leave level_o unchanged.
REQ-026 When inactive, the request outputs read: req_o=0, we_o=0, be_o=0, addr_o=pointer, wdata_o=0.

Reset
REQ-027 Asserting rst aborts any transaction immediately, with no completion or retry.
REQ-028 Reset values: state IDLE, FIFO empty, level_o=0, wr_ready_o=1, req_o=0, we_o=0, be_o=0, wdata_o=0, pointer=0, addr_o=0, count_o=0, busy_o=0, addr_err_o=0, mismatch_o=0.
REQ-029 Outputs become valid on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro OBI_LOADER_READBACK_EN enables read-back verification.
REQ-031 With the macro: REQ_W -> WAIT_W -> REQ_R (req_o=1, we_o=0, be_o=4'hF, same address) -> WAIT_R. On rvalid_i, compare rdata_i with the stored word; on mismatch set mismatch_o sticky. Then advance the pointer and count_o, and return to IDLE.
REQ-032 Without the macro: the REQ_R and WAIT_R states and the compare logic are absent, and mismatch_o is tied to 0.

Verification
REQ-033 Base 0x0000_1000 loaded; push 3 words, single-cycle gnt and rvalid -> writes go to 0x1000, 0x1004 and 0x1008 in order; count_o=3; busy_o=0 afterwards.
REQ-034 Push DEPTH+1 words with gnt_i held low -> wr_ready_o=0 at level_o=DEPTH, the extra word is not accepted, and addr_o/wdata_o stay stable while req_o=1.
REQ-035 Base load while busy -> addr_err_o pulses for one cycle and the pointer is unchanged; base 0xFFFF_FFFC plus 2 words -> writes go to 0xFFFF_FFFC, then 0x0000_0000.
REQ-036 rst asserted in WAIT_W -> req_o=0, level_o=0 and count_o=0 in the same cycle; a later rvalid_i has no effect.
REQ-037 READBACK_EN: write 0xDEADBEEF, read returns 0xDEADBEEE -> mismatch_o=1 and stays set until the next accepted base load.
REQ-038 Simultaneous base load (0x2000) and push while idle -> the word is written to 0x2000.
